oh_add_seq: RTL and testbench
=============================

Name: oh_add_seq

Overview:
- Word-serial multi-precision add/subtract sequencer.
- Chains one DW-bit two's-complement adder/subtractor across a stream of operand words, least significant word first, to form arbitrarily wide sums.
- Owns carry chaining, transaction framing, a word counter, output buffering with valid/ready backpressure, and the whole-number status flags.
- Sits between an operand streamer (DMA or register front end) and a result sink in the arithmetic datapath.

Parameters:
- DW, 32, data word width in bits (>=2).
- MAXW, 8, maximum number of words per transaction (>=1).
- CW, $clog2(MAXW+1), width of the word counter (derived; do not override).

Ports:
- clk, input, 1, clock.
- nreset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand word valid.
- in_ready, output, 1, operand word accepted when in_valid & in_ready.
- in_a, input, DW, operand A word.
- in_b, input, DW, operand B word.
- in_sub, input, 1, 1 = A-B; sampled on the first beat of a transaction only.
- in_last, input, 1, final (most significant) word of the transaction.
- out_valid, output, 1, result word valid.
- out_ready, input, 1, result word consumed when out_valid & out_ready.
- out_sum, output, DW, result word.
- out_last, output, 1, final result word; the flags below are valid only when this is 1.
- out_cout, output, 1, carry out of the final word (subtract: 1 = no borrow).
- out_zero, output, 1, every result word of the transaction was zero.
- out_neg, output, 1, MSB of the final result word.
- out_overflow, output, 1, signed overflow of the whole-number result.
- out_err, output, 1, transaction force-terminated at MAXW words.
- out_count, output, CW, number of words in the transaction.

Behaviour:
- Reset (nreset low, asynchronous):
  - out_valid=0; out_sum, out_last, all flags and out_count=0.
  - carry=0, first=1, sub latch=0, word count=0, zero accumulator=1.
  - Takes effect immediately, including mid-transaction; any partial transaction is discarded.
- Handshake:
  - in_ready = ~out_valid | out_ready (single output register stage).
  - Latency is 1 cycle from an accepted input beat to out_valid.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Per accepted beat:
  - opsub = first ? in_sub : sub latch.
  - b' = in_b XOR {DW{opsub}}.
  - cin = first ? opsub : carry.
  - {c, out_sum} = in_a + b' + cin.
  - carry <= c.
  - On the first beat, the sub latch <= in_sub.
- Word count:
  - count <= first ? 1 : count+1.
  - zero accumulator <= (first ? 1 : acc) & (sum==0).
- Termination:
  - A beat is terminal if in_last=1, or if it is word number MAXW.
  - If termination is caused by MAXW with in_last=0, out_err=1.
  - Terminal beat: out_last=1, out_count=count, out_cout=c, out_neg=sum[DW-1], out_zero=acc result.
  - out_overflow = carry into bit DW-1 XOR c.
  - After a terminal beat, first<=1; the next beat starts a new transaction.
- Non-terminal beats: out_last=0, all flags and out_count=0.
- MAXW=1: every beat is terminal; out_err=1 whenever in_last=0.
- Simultaneous output consume and input accept in the same cycle: full throughput, one word per cycle, no bubble.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: OH_ADD_SEQ_CIN_EN.
- Defined:
  - Adds input port in_cin (1 bit), sampled on the first beat only.
  - First-word carry-in = in_sub ? ~in_cin : in_cin.
  - For subtraction, in_cin acts as borrow-in, which allows this block to be chained after another sequencer.
- Not defined:
  - The in_cin port does not exist.
  - First-word carry-in = in_sub.

Test Plan (DW=8, MAXW=4, out_ready=1 unless stated):
1. Single word, add 0x7F+0x01 with in_last=1 -> out_sum=0x80, out_last=1, cout=0, neg=1, overflow=1, zero=0, count=1, err=0.
2. Two-word add, A words {0xFF,0x00}, B words {0x01,0x00} -> out_sum 0x00 then 0x01, last word has cout=0, zero=0, overflow=0, count=2.
3. Two-word subtract 0x0100-0x0001, A words {0x00,0x01}, B words {0x01,0x00}, in_sub=1 on first beat only -> out_sum 0xFF then 0x00, cout=1, zero=0, neg=0, overflow=0.
4. Backpressure: a 3-word add with out_ready low for 3 cycles after word 1 -> in_ready low, out_* stable, no word lost or duplicated, carry chain still correct.
5. MAXW termination: 4 beats of 0x01+0x01 with in_last=0, then a 5th beat 0x05-0x03 with in_sub=1 and in_last=1:
   - 4th output: last=1, err=1, count=4.
   - 5th output: 0x02, count=1, carry-in reinitialised.
6. Reset mid-transaction: drop nreset after word 1 of 3 -> out_valid=0 immediately; then single-word 0x05-0x05 -> out_sum=0x00, zero=1, cout=1, count=1.

Source files
------------

// File: rtl/oh_add_seq_if.sv
// Operand/result stream bundle for oh_add_seq.
// When OH_ADD_SEQ_CIN_EN is defined the bundle also carries in_cin.
interface oh_add_seq_if #(
    parameter int DW   = 32,
    parameter int MAXW = 8
);
    localparam int CW = $clog2(MAXW + 1);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_sub;
    logic          in_last;
`ifdef OH_ADD_SEQ_CIN_EN
    logic          in_cin;
`endif

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_zero;
    logic          out_neg;
    logic          out_overflow;
    logic          out_err;
    logic [CW-1:0] out_count;

    modport slave (
`ifdef OH_ADD_SEQ_CIN_EN
        input  in_cin,
`endif
        input  in_valid, in_a, in_b, in_sub, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_zero,
               out_neg, out_overflow, out_err, out_count
    );

    modport master (
`ifdef OH_ADD_SEQ_CIN_EN
        output in_cin,
`endif
        output in_valid, in_a, in_b, in_sub, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_zero,
               out_neg, out_overflow, out_err, out_count
    );
endinterface

// File: rtl/oh_add_seq.sv
// Word-serial multi-precision add/subtract sequencer, least significant word first.
// Optional macro OH_ADD_SEQ_CIN_EN adds a first-beat carry/borrow input (in_cin).
module oh_add_seq #(
    parameter int DW   = 32,
    parameter int MAXW = 8
) (
    input  logic        clk,
    input  logic        nreset,
    oh_add_seq_if.slave bus
);
    localparam int CW = $clog2(MAXW + 1);

    logic          first;
    logic          carry;
    logic          sub_q;
    logic          zacc;
    logic [CW-1:0] count_q;

    logic          fire;
    logic          first_cin;
    logic          opsub;
    logic          cin;
    logic [DW-1:0] b_x;
    logic [DW-1:0] low;
    logic          c_msb;
    logic [1:0]    top;
    logic [DW-1:0] sum;
    logic          c_out;
    logic [CW-1:0] count_next;
    logic          zero_next;
    logic          terminal;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign fire         = bus.in_valid & bus.in_ready;

`ifdef OH_ADD_SEQ_CIN_EN
    assign first_cin = bus.in_sub ? ~bus.in_cin : bus.in_cin;
`else
    assign first_cin = bus.in_sub;
`endif

    // Adder split below the MSB so the carry into bit DW-1 is available for overflow.
    always_comb begin
        opsub      = first ? bus.in_sub : sub_q;
        b_x        = bus.in_b ^ {DW{opsub}};
        cin        = first ? first_cin : carry;
        low        = {1'b0, bus.in_a[DW-2:0]} + {1'b0, b_x[DW-2:0]} + {{(DW-1){1'b0}}, cin};
        c_msb      = low[DW-1];
        top        = {1'b0, bus.in_a[DW-1]} + {1'b0, b_x[DW-1]} + {1'b0, c_msb};
        sum        = {top[0], low[DW-2:0]};
        c_out      = top[1];
        count_next = first ? CW'(1) : count_q + CW'(1);
        zero_next  = (first | zacc) & (sum == '0);
        terminal   = bus.in_last | (count_next == CW'(MAXW));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            first   <= 1'b1;
            carry   <= 1'b0;
            sub_q   <= 1'b0;
            zacc    <= 1'b1;
            count_q <= '0;
        end else if (fire) begin
            first   <= terminal;
            carry   <= c_out;
            zacc    <= zero_next;
            count_q <= count_next;
            if (first) begin
                sub_q <= bus.in_sub;
            end
        end
    end

    // Single output register stage; whole-number flags only on the terminal word.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bus.out_valid    <= 1'b0;
            bus.out_sum      <= '0;
            bus.out_last     <= 1'b0;
            bus.out_cout     <= 1'b0;
            bus.out_zero     <= 1'b0;
            bus.out_neg      <= 1'b0;
            bus.out_overflow <= 1'b0;
            bus.out_err      <= 1'b0;
            bus.out_count    <= '0;
        end else if (fire) begin
            bus.out_valid    <= 1'b1;
            bus.out_sum      <= sum;
            bus.out_last     <= terminal;
            bus.out_cout     <= terminal & c_out;
            bus.out_zero     <= terminal & zero_next;
            bus.out_neg      <= terminal & sum[DW-1];
            bus.out_overflow <= terminal & (c_msb ^ c_out);
            bus.out_err      <= terminal & ~bus.in_last;
            bus.out_count    <= terminal ? count_next : '0;
        end else if (bus.out_ready) begin
            bus.out_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_oh_add_seq.sv
// Scoreboard bench for oh_add_seq: whole-number reference model, randomized and directed beats.
// Drives in_cin as well when OH_ADD_SEQ_CIN_EN is defined.
module tb_oh_add_seq;
    localparam int DW   = 8;
    localparam int MAXW = 4;
    localparam int CW   = $clog2(MAXW + 1);

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    oh_add_seq_if #(.DW(DW), .MAXW(MAXW)) bus ();
    oh_add_seq #(.DW(DW), .MAXW(MAXW)) dut (.clk(clk), .nreset(nreset), .bus(bus));

    typedef struct packed {
        logic [DW-1:0] sum;
        logic          last;
        logic          cout;
        logic          zero;
        logic          neg;
        logic          ovf;
        logic          err;
        logic [CW-1:0] count;
    } resp_t;

    resp_t  exp_q[$];
    int     checks    = 0;
    int     failures  = 0;
    bit     bp_random = 1'b0;
    bit     bp_low    = 1'b0;

    bit     m_first = 1'b1;
    bit     m_sub;
    bit     m_c0;
    longint m_a;
    longint m_b;
    int     m_k;

    // Result of the transaction so far as one wide number; its top word is this beat's output.
    function automatic resp_t modelBeat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input bit sub, input bit last, input bit cin);
        resp_t  r;
        longint av, bv, w, mask, half, bx, full, sa, sb, res;
        bit     term;
        av = a;
        bv = b;
        if (m_first) begin
            m_a   = 0;
            m_b   = 0;
            m_k   = 0;
            m_sub = sub;
            m_c0  = sub ? ~cin : cin;
        end
        m_a  = m_a + (av << (DW * m_k));
        m_b  = m_b + (bv << (DW * m_k));
        m_k  = m_k + 1;
        w    = DW * m_k;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        bx   = m_sub ? (~m_b & mask) : m_b;
        full = m_a + bx + longint'(m_c0);
        sa   = (m_a >= half) ? m_a - (mask + 1) : m_a;
        sb   = (bx >= half) ? bx - (mask + 1) : bx;
        res  = sa + sb + longint'(m_c0);
        term = last || (m_k == MAXW);
        r       = '0;
        r.sum   = DW'((full >> (w - DW)) & 255);
        r.last  = term;
        if (term) begin
            r.cout  = ((full >> w) & 1) != 0;
            r.zero  = (full & mask) == 0;
            r.neg   = ((full >> (w - 1)) & 1) != 0;
            r.ovf   = (res < -half) || (res > half - 1);
            r.err   = !last;
            r.count = CW'(m_k);
        end
        m_first = term;
        return r;
    endfunction

    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input bit sub, input bit last);
        bit ok;
        bit cin;
        int waitc;
        cin = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_last  = last;
`ifdef OH_ADD_SEQ_CIN_EN
        cin        = 1'($urandom_range(0, 1));
        bus.in_cin = cin;
`endif
        ok    = 1'b0;
        waitc = 0;
        while (!ok) begin
            #4;
            ok = bus.in_ready;
            @(posedge clk);
            if (!ok) begin
                waitc++;
                if (waitc > 200) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL in_ready timeout: got in_ready=0 for %0d cycles, required 1", waitc);
                    bus.in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        exp_q.push_back(modelBeat(a, b, sub, last, cin));
    endtask

    task automatic checkOutput(input resp_t act);
        resp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected word: got sum=%h last=%b, required no output", act.sum, act.last);
            return;
        end
        e = exp_q.pop_front();
        if (act !== e) begin
            failures++;
            $display("[TB] FAIL result word: got sum=%h last=%b cout=%b zero=%b neg=%b ovf=%b err=%b count=%0d, required sum=%h last=%b cout=%b zero=%b neg=%b ovf=%b err=%b count=%0d",
                     act.sum, act.last, act.cout, act.zero, act.neg, act.ovf, act.err, act.count,
                     e.sum, e.last, e.cout, e.zero, e.neg, e.ovf, e.err, e.count);
        end
    endtask

    task automatic idleInput();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d words still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic checkResetState(input string name);
        logic [DW+CW+7:0] act;
        act = {bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout, bus.out_zero,
               bus.out_neg, bus.out_overflow, bus.out_err, bus.out_count};
        checks++;
        if (act !== '0) begin
            failures++;
            $display("[TB] FAIL %s: got outputs=%h, required all zero", name, act);
        end
    endtask

    // Sink: full-rate, randomly stalled, or held off for directed backpressure.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = bp_low ? 1'b0 : (bp_random ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor samples one time unit before each rising edge.
    initial begin
        resp_t act;
        resp_t held;
        bit    stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!nreset) begin
                stalled = 1'b0;
                continue;
            end
            act = '{bus.out_sum, bus.out_last, bus.out_cout, bus.out_zero, bus.out_neg,
                    bus.out_overflow, bus.out_err, bus.out_count};
            if (stalled) begin
                checks++;
                if (act !== held || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stall hold: got valid=%b word=%h, required valid=1 word=%h", bus.out_valid, act, held);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall in_ready: got %b, required 0", bus.in_ready);
                end
                held    = act;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                checkOutput(act);
            end
        end
    end

    initial begin
        int len;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_sub   = 1'b0;
        bus.in_last  = 1'b0;
`ifdef OH_ADD_SEQ_CIN_EN
        bus.in_cin   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkResetState("reset state");
        nreset = 1'b1;

        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b0);
        applyStimulus(8'h01, 8'h00, 1'b0, 1'b1);
        idleInput();
        drain();

        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        bp_low = 1'b1;
        fork
            begin
                repeat (3) @(posedge clk);
                bp_low = 1'b0;
            end
        join_none
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
        idleInput();
        drain();

        for (int i = 0; i < 4; i++) applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h05, 8'h03, 1'b1, 1'b1);
        idleInput();
        drain();

        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        #2;
        nreset       = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checkResetState("mid-transaction reset");
        exp_q.delete();
        m_first = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        applyStimulus(8'h05, 8'h05, 1'b1, 1'b1);
        idleInput();
        drain();

        bp_random = 1'b1;
        for (int t = 0; t < 150; t++) begin
            len = $urandom_range(1, MAXW + 1);
            for (int i = 0; i < len; i++) begin
                applyStimulus(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), i == len - 1);
            end
            if ($urandom_range(0, 3) == 0) idleInput();
        end
        idleInput();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
